// File: rtl/zvc_line_packer_if.sv
`default_nettype none
// ============================================================================
// Module   : zvc_line_packer_if
// Purpose  : Beat-in / line-out handshake bundle for the ZVC line packer.
//            The master side produces compressed beats and consumes packed
//            lines. The slave side is the packer itself.
// Revision : 1.0  initial release
// ============================================================================
interface zvc_line_packer_if #(
  parameter int WORD_WIDTH    = 8,
  parameter int LINE_SIZE     = 32,
  parameter int DIST_WIDTH    = 7,
  parameter int MAX_LIFM_RSIZ = 3,
  parameter int CNT_WIDTH     = 6
);
  localparam int MW = DIST_WIDTH * MAX_LIFM_RSIZ;

  logic                            in_valid;
  logic                            in_ready;
  logic [LINE_SIZE*WORD_WIDTH-1:0] in_lifm;
  logic [LINE_SIZE*MW-1:0]         in_mt;
  logic [CNT_WIDTH-1:0]            in_cnt;
  logic                            in_last;

  logic                            out_valid;
  logic                            out_ready;
  logic [LINE_SIZE*WORD_WIDTH-1:0] out_lifm;
  logic [LINE_SIZE*MW-1:0]         out_mt;
  logic [CNT_WIDTH-1:0]            out_cnt;
  logic                            out_last;

  modport master (
    output in_valid, in_lifm, in_mt, in_cnt, in_last, out_ready,
    input  in_ready, out_valid, out_lifm, out_mt, out_cnt, out_last
  );

  modport slave (
    input  in_valid, in_lifm, in_mt, in_cnt, in_last, out_ready,
    output in_ready, out_valid, out_lifm, out_mt, out_cnt, out_last
  );
endinterface
`default_nettype wire

// File: rtl/zvc_line_packer.sv
`default_nettype none
// ============================================================================
// Module   : zvc_line_packer
// Purpose  : Concatenates variable-length compressed beats (words + MT
//            entries) into dense LINE_SIZE-word lines; an in_last beat
//            flushes the trailing partial line.
// Revision : 1.0  initial release
// ============================================================================
module zvc_line_packer #(
  parameter int WORD_WIDTH    = 8,
  parameter int LINE_SIZE     = 32,
  parameter int DIST_WIDTH    = 7,
  parameter int MAX_LIFM_RSIZ = 3,
  parameter int CNT_WIDTH     = 6
) (
  input  logic              clk,
  input  logic              reset_n,
  zvc_line_packer_if.slave  bus
);
  localparam int MW    = DIST_WIDTH * MAX_LIFM_RSIZ;
  localparam int SLOTS = 2 * LINE_SIZE;
  localparam int FW    = $clog2(SLOTS);
  localparam int LW    = LINE_SIZE * WORD_WIDTH;
  localparam int LM    = LINE_SIZE * MW;
  localparam int BW    = SLOTS * WORD_WIDTH;
  localparam int BM    = SLOTS * MW;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    FLUSH = 1'b1
  } state_t;

  state_t          state, state_nxt;
  logic [FW-1:0]   fill, fill_nxt;
  logic [BW-1:0]   lifm_q, lifm_d;
  logic [BM-1:0]   mt_q, mt_d;
  logic [LW-1:0]   in_lifm_m;
  logic [LM-1:0]   in_mt_m;

  int              fill_i, cnt_i, out_cnt_i, f_mid, f_after;
  logic            out_valid, out_last, in_ready, pop, push;

  // Handshake decode and fill bookkeeping (pop is applied before push)
  always_comb begin
    fill_i    = int'(fill);
    cnt_i     = int'(bus.in_cnt);
    if (cnt_i > LINE_SIZE) cnt_i = LINE_SIZE;
    out_cnt_i = (fill_i < LINE_SIZE) ? fill_i : LINE_SIZE;
    out_valid = (fill_i >= LINE_SIZE) || ((state == FLUSH) && (fill_i > 0));
    out_last  = (state == FLUSH) && (fill_i <= LINE_SIZE) && out_valid;
    in_ready  = (state == ACCUM) && ((fill_i < LINE_SIZE) || bus.out_ready);
    pop       = out_valid && bus.out_ready;
    push      = bus.in_valid && in_ready;
    f_mid     = pop ? (fill_i - out_cnt_i) : fill_i;
    f_after   = push ? (f_mid + cnt_i) : f_mid;
    fill_nxt  = FW'(f_after);
  end

  // Buffer update: shift out the popped line, then OR the masked beat in
  // above the surviving words (everything above the fill is always zero)
  always_comb begin
    in_lifm_m = '0;
    in_mt_m   = '0;
    for (int i = 0; i < LINE_SIZE; i++) begin
      if (i < cnt_i) begin
        in_lifm_m[i*WORD_WIDTH +: WORD_WIDTH] = bus.in_lifm[i*WORD_WIDTH +: WORD_WIDTH];
        in_mt_m[i*MW +: MW]                   = bus.in_mt[i*MW +: MW];
      end
    end
    lifm_d = lifm_q;
    mt_d   = mt_q;
    if (pop) begin
      lifm_d = lifm_q >> (out_cnt_i * WORD_WIDTH);
      mt_d   = mt_q >> (out_cnt_i * MW);
    end
    if (push) begin
      lifm_d = lifm_d | ({{(BW-LW){1'b0}}, in_lifm_m} << (f_mid * WORD_WIDTH));
      mt_d   = mt_d | ({{(BM-LM){1'b0}}, in_mt_m} << (f_mid * MW));
    end
  end

  // Next-state: enter FLUSH on a non-empty last beat, leave on the final pop
  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM:   if (push && bus.in_last && (f_after > 0)) state_nxt = FLUSH;
      FLUSH:   if (pop && out_last) state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  // State, fill and buffer registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state  <= ACCUM;
      fill   <= '0;
      lifm_q <= '0;
      mt_q   <= '0;
    end else begin
      state  <= state_nxt;
      fill   <= fill_nxt;
      lifm_q <= lifm_d;
      mt_q   <= mt_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.out_last  = out_last;
  assign bus.out_cnt   = CNT_WIDTH'(out_cnt_i);
  assign bus.out_lifm  = lifm_q[LW-1:0];
  assign bus.out_mt    = mt_q[LM-1:0];

endmodule
`default_nettype wire

// File: tb/tb_zvc_line_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_zvc_line_packer
// Purpose  : Directed and random self-checking bench for zvc_line_packer
//            at LINE_SIZE=4.
// Revision : 1.0  initial release
// ============================================================================
module tb_zvc_line_packer;
  localparam int L  = 4;
  localparam int WW = 8;
  localparam int MW = 21;

  localparam logic [7:0] WA = 8'hA1, WB = 8'hB2, WC = 8'hC3, WD = 8'hD4;
  localparam logic [7:0] WE = 8'hE5, WF = 8'hF6, WG = 8'h17, WH = 8'h28;
  localparam logic [7:0] WI = 8'h39, WJ = 8'h4A, WK = 8'h5B, WL = 8'h6C;
  localparam logic [7:0] WM = 8'h7D, WN = 8'h8E, WP = 8'h9F, WQ = 8'h10;
  localparam logic [7:0] WR = 8'h21, WS = 8'h32, XX = 8'hEE;

  logic clk = 1'b0;
  logic reset_n;
  int   n_checks;
  int   n_fail;

  always #5 clk = ~clk;

  zvc_line_packer_if #(.WORD_WIDTH(WW), .LINE_SIZE(L), .DIST_WIDTH(7),
                       .MAX_LIFM_RSIZ(3), .CNT_WIDTH(6)) bus_i ();

  zvc_line_packer #(.WORD_WIDTH(WW), .LINE_SIZE(L), .DIST_WIDTH(7),
                    .MAX_LIFM_RSIZ(3), .CNT_WIDTH(6)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_i)
  );

  // Illegal beat sizes must never be driven
  always @(posedge clk) begin
    if (reset_n && bus_i.in_valid)
      assert (bus_i.in_cnt <= 6'(L)) else $error("in_cnt out of range: %0d", bus_i.in_cnt);
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [MW-1:0] mt_of(input logic [7:0] w);
    return {5'h15, w, w};
  endfunction

  function automatic logic [L*WW-1:0] line_l(input logic [7:0] w0, w1, w2, w3);
    return {w3, w2, w1, w0};
  endfunction

  function automatic logic [L*MW-1:0] line_m(input logic [7:0] w0, w1, w2, w3, input int n);
    logic [L*MW-1:0] r;
    r = '0;
    if (n > 0) r[0*MW +: MW] = mt_of(w0);
    if (n > 1) r[1*MW +: MW] = mt_of(w1);
    if (n > 2) r[2*MW +: MW] = mt_of(w2);
    if (n > 3) r[3*MW +: MW] = mt_of(w3);
    return r;
  endfunction

  task automatic set_beat(input logic v, input logic [7:0] w0, w1, w2, w3,
                          input int cnt, input logic last);
    bus_i.in_valid = v;
    bus_i.in_lifm  = {w3, w2, w1, w0};
    bus_i.in_mt    = {mt_of(w3), mt_of(w2), mt_of(w1), mt_of(w0)};
    bus_i.in_cnt   = 6'(cnt);
    bus_i.in_last  = last;
  endtask

  task automatic idle();
    set_beat(1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_empty(input string tag);
    check({tag, "_valid"}, bus_i.out_valid, 1'b0);
    check({tag, "_ready"}, bus_i.in_ready, 1'b1);
    check({tag, "_cnt"},   bus_i.out_cnt, 6'd0);
    check({tag, "_lifm"},  bus_i.out_lifm, '0);
    check({tag, "_mt"},    bus_i.out_mt, '0);
    check({tag, "_last"},  bus_i.out_last, 1'b0);
  endtask

  logic [7:0]      q[$];
  bit              m_flush;
  int              beats, cyc, n;
  logic            v, last, exp_valid, exp_ready;
  int              cnt;
  logic [7:0]      w[4];
  logic [L*WW-1:0] el;
  logic [L*MW-1:0] em;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    idle();
    bus_i.out_ready = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    #1;
    check_empty("rst");

    // 1: build a 3-word flush, then reset over it
    set_beat(1'b1, WA, WB, WC, XX, 3, 1'b1);
    #1;
    check("t1_in_ready", bus_i.in_ready, 1'b1);
    step();
    idle();
    #1;
    check("t1_valid", bus_i.out_valid, 1'b1);
    check("t1_cnt",   bus_i.out_cnt, 6'd3);
    check("t1_last",  bus_i.out_last, 1'b1);
    check("t1_lifm",  bus_i.out_lifm, line_l(WA, WB, WC, 8'h00));
    check("t1_ready", bus_i.in_ready, 1'b0);
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    #1;
    check_empty("t1_rst");
    step();
    check("t1_post_valid", bus_i.out_valid, 1'b0);

    // 2: two 3-word beats form one full line
    bus_i.out_ready = 1'b1;
    set_beat(1'b1, WA, WB, WC, XX, 3, 1'b0);
    step();
    set_beat(1'b1, WD, WE, WF, XX, 3, 1'b0);
    #1;
    check("t2_pre_valid", bus_i.out_valid, 1'b0);
    check("t2_pre_ready", bus_i.in_ready, 1'b1);
    step();
    idle();
    #1;
    check("t2_valid", bus_i.out_valid, 1'b1);
    check("t2_cnt",   bus_i.out_cnt, 6'd4);
    check("t2_last",  bus_i.out_last, 1'b0);
    check("t2_lifm",  bus_i.out_lifm, line_l(WA, WB, WC, WD));
    check("t2_mt",    bus_i.out_mt, line_m(WA, WB, WC, WD, 4));

    // 3: last beat of one word while the full line pops
    set_beat(1'b1, WG, XX, XX, XX, 1, 1'b1);
    #1;
    check("t3_in_ready", bus_i.in_ready, 1'b1);
    step();
    idle();
    #1;
    check("t3_valid", bus_i.out_valid, 1'b1);
    check("t3_cnt",   bus_i.out_cnt, 6'd3);
    check("t3_last",  bus_i.out_last, 1'b1);
    check("t3_lifm",  bus_i.out_lifm, line_l(WE, WF, WG, 8'h00));
    check("t3_mt",    bus_i.out_mt, line_m(WE, WF, WG, 8'h00, 3));
    check("t3_ready", bus_i.in_ready, 1'b0);
    step();
    check_empty("t3_done");

    // 4: backpressure at F=7, then simultaneous pop and push
    bus_i.out_ready = 1'b0;
    set_beat(1'b1, WH, WI, WJ, XX, 3, 1'b0);
    step();
    set_beat(1'b1, WK, WL, WM, WN, 4, 1'b0);
    step();
    set_beat(1'b1, WP, WQ, WR, WS, 4, 1'b0);
    #1;
    for (int i = 0; i < 5; i++) begin
      check("t4_hold_ready", bus_i.in_ready, 1'b0);
      check("t4_hold_valid", bus_i.out_valid, 1'b1);
      check("t4_hold_cnt",   bus_i.out_cnt, 6'd4);
      check("t4_hold_lifm",  bus_i.out_lifm, line_l(WH, WI, WJ, WK));
      check("t4_hold_mt",    bus_i.out_mt, line_m(WH, WI, WJ, WK, 4));
      step();
    end
    bus_i.out_ready = 1'b1;
    #1;
    check("t4_ready_comb", bus_i.in_ready, 1'b1);
    step();
    idle();
    #1;
    check("t4_pp_valid", bus_i.out_valid, 1'b1);
    check("t4_pp_cnt",   bus_i.out_cnt, 6'd4);
    check("t4_pp_lifm",  bus_i.out_lifm, line_l(WL, WM, WN, WP));
    check("t4_pp_mt",    bus_i.out_mt, line_m(WL, WM, WN, WP, 4));
    step();
    check("t4_rem_valid", bus_i.out_valid, 1'b0);
    check("t4_rem_ready", bus_i.in_ready, 1'b1);
    check("t4_rem_cnt",   bus_i.out_cnt, 6'd3);
    check("t4_rem_lifm",  bus_i.out_lifm, line_l(WQ, WR, WS, 8'h00));
    set_beat(1'b1, XX, XX, XX, XX, 0, 1'b1);
    step();
    idle();
    #1;
    check("t4_fl_valid", bus_i.out_valid, 1'b1);
    check("t4_fl_last",  bus_i.out_last, 1'b1);
    check("t4_fl_cnt",   bus_i.out_cnt, 6'd3);
    check("t4_fl_mt",    bus_i.out_mt, line_m(WQ, WR, WS, 8'h00, 3));
    step();
    check_empty("t4_done");

    // 5: empty last beat on an empty buffer emits nothing
    set_beat(1'b1, XX, XX, XX, XX, 0, 1'b1);
    step();
    idle();
    #1;
    check_empty("t5_a");
    step();
    check_empty("t5_b");

    // 6: random beats and backpressure against a word-queue model
    m_flush = 1'b0;
    beats   = 0;
    cyc     = 0;
    while (beats < 10000 && cyc < 50000) begin
      v    = ($urandom_range(3) != 0);
      cnt  = $urandom_range(4);
      last = ($urandom_range(15) == 0);
      for (int i = 0; i < 4; i++) w[i] = 8'($urandom);
      set_beat(v, w[0], w[1], w[2], w[3], cnt, last);
      bus_i.out_ready = ($urandom_range(3) != 0);
      #1;
      exp_valid = (q.size() >= L) || (m_flush && q.size() > 0);
      exp_ready = !m_flush && ((q.size() < L) || bus_i.out_ready);
      check("r_valid", bus_i.out_valid, exp_valid);
      check("r_ready", bus_i.in_ready, exp_ready);
      if (exp_valid && bus_i.out_ready) begin
        n  = (q.size() < L) ? q.size() : L;
        el = '0;
        em = '0;
        for (int i = 0; i < n; i++) begin
          el[i*WW +: WW] = q[i];
          em[i*MW +: MW] = mt_of(q[i]);
        end
        check("r_cnt",  bus_i.out_cnt, 6'(n));
        check("r_last", bus_i.out_last, m_flush && (q.size() <= L));
        check("r_lifm", bus_i.out_lifm, el);
        check("r_mt",   bus_i.out_mt, em);
        for (int i = 0; i < n; i++) void'(q.pop_front());
        if (m_flush && q.size() == 0) m_flush = 1'b0;
      end
      if (v && exp_ready) begin
        for (int i = 0; i < cnt; i++) q.push_back(w[i]);
        beats++;
        if (last && q.size() > 0) m_flush = 1'b1;
      end
      step();
      cyc++;
    end
    check("r_beats", beats, 10000);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
